// File: rtl/v_fifo_sched_pkg.sv
// Shared types and helpers for the vector FIFO sequencing controller.
package v_fifo_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REWIND = 2'd2
    } sched_state_t;

    // Occupancy must be able to represent Cap itself, hence the extra bit.
    function automatic int occ_width(input int cap);
        return $clog2(cap) + 1;
    endfunction

endpackage

// File: rtl/v_fifo_sched.sv
// Flow control and replay sequencing for one vector FIFO: occupancy tracking,
// valid/ready on both sides, and cfg_passes reads of each vector before release.
module v_fifo_sched
    import v_fifo_sched_pkg::*;
#(
    parameter int VecElements      = 16,
    parameter int ElementsPerWrite = 2,
    parameter int ElementsPerRead  = 4,
    parameter int Depth            = 4,
    parameter int PassBits         = 8,
    localparam int Cap  = Depth * VecElements,
    localparam int OccW = occ_width(Cap),
    localparam int OffW = $clog2(VecElements) + 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                cfg_start,
    input  logic [PassBits-1:0] cfg_passes,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                m_ready,
    output logic                m_valid,
    output logic                m_last_beat,
    output logic                m_last_pass,
    output logic                fifo_rst_n,
    output logic                fifo_wr_en,
    output logic                fifo_rd_en,
    output logic                fifo_wrap_rd,
    output logic [OccW-1:0]     occupancy,
    output logic [PassBits-1:0] pass_idx,
    output logic                vec_done,
    output logic [1:0]          dbg_state
);

    if (VecElements % ElementsPerWrite != 0) begin : g_bad_epw
        $error("VecElements must be a multiple of ElementsPerWrite");
    end
    if (VecElements % ElementsPerRead != 0) begin : g_bad_epr
        $error("VecElements must be a multiple of ElementsPerRead");
    end

    localparam logic [OccW:0]   CapX     = (OccW+1)'(Cap);
    localparam logic [OccW:0]   EpwX     = (OccW+1)'(ElementsPerWrite);
    localparam logic [OccW:0]   EprX     = (OccW+1)'(ElementsPerRead);
    localparam logic [OccW-1:0] EpwOcc   = OccW'(ElementsPerWrite);
    localparam logic [OccW-1:0] VecOcc   = OccW'(VecElements);
    localparam logic [OffW-1:0] EprOff   = OffW'(ElementsPerRead);
    localparam logic [OffW-1:0] LastOff  = OffW'(VecElements - ElementsPerRead);

    sched_state_t        state_q, state_d;
    logic [OccW-1:0]     occ_q;
    logic [OffW-1:0]     rd_off_q;
    logic [PassBits-1:0] pass_q;
    logic [PassBits-1:0] passes_q;
    logic                vec_done_q;
    logic                release_vec;

    // Valid/ready: a beat transfers on a side exactly when that side's valid and
    // ready are both high at the rising edge; neither valid waits on its ready.
    // Both readiness terms use registered state only, so a same-cycle read never
    // frees write space and a same-cycle write never exposes new read data.
    assign s_ready      = ({1'b0, occ_q} + EpwX) <= CapX;
    assign m_valid      = (state_q == RUN) && !rst_in &&
                          ({1'b0, occ_q} >= ((OccW+1)'(rd_off_q) + EprX));
    assign fifo_wr_en   = s_valid & s_ready & ~rst_in;
    assign fifo_rd_en   = m_valid & m_ready;
    assign fifo_wrap_rd = (state_q == REWIND) && !rst_in;
    assign fifo_rst_n   = ~rst_in;
    assign m_last_beat  = (rd_off_q == LastOff);
    assign m_last_pass  = (pass_q == passes_q - PassBits'(1));
    assign release_vec  = fifo_rd_en & m_last_beat & m_last_pass;

    assign occupancy = occ_q;
    assign pass_idx  = pass_q;
    assign vec_done  = vec_done_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_start) state_d = RUN;
            RUN:     if (fifo_rd_en && m_last_beat && !m_last_pass) state_d = REWIND;
            REWIND:  state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            occ_q      <= '0;
            rd_off_q   <= '0;
            pass_q     <= '0;
            passes_q   <= '0;
            vec_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_done_q <= release_vec;
            if (state_q == IDLE && cfg_start) begin
                passes_q <= (cfg_passes == '0) ? PassBits'(1) : cfg_passes;
            end
            // Write credit and vector release are folded into one update.
            occ_q <= occ_q + (fifo_wr_en ? EpwOcc : '0) - (release_vec ? VecOcc : '0);
            if (fifo_rd_en) begin
                if (m_last_beat) begin
                    rd_off_q <= '0;
                    pass_q   <= m_last_pass ? '0 : pass_q + PassBits'(1);
                end else begin
                    rd_off_q <= rd_off_q + EprOff;
                end
            end
        end
    end

endmodule
